// File: rtl/alu_if.sv
// Operand/opcode bundle into the ALU and registered result/branch flags back out.
interface alu_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
);
    logic [DATA_WIDTH-1:0]    rs1;
    logic [DATA_WIDTH-1:0]    rs2;
    logic [OPCODE_LENGTH-1:0] Opcode;
    logic [DATA_WIDTH-1:0]    rd;
    logic                     Con_BLT;
    logic                     Con_BGT;
    logic                     zero;

    modport master (
        output rs1, rs2, Opcode,
        input  rd, Con_BLT, Con_BGT, zero
    );

    modport slave (
        input  rs1, rs2, Opcode,
        output rd, Con_BLT, Con_BGT, zero
    );
endinterface

// File: rtl/alu.sv
// Registered integer ALU: one operation per clock, result and branch flags
// appear one cycle after the operands are sampled.
module alu #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input logic   clk,
    input logic   rst_n,
    alu_if.slave  bus
);
    localparam int SH_W = $clog2(DATA_WIDTH);

    localparam logic [OPCODE_LENGTH-1:0] OP_NOP   = OPCODE_LENGTH'(5'b00000);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = OPCODE_LENGTH'(5'b00001);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB   = OPCODE_LENGTH'(5'b00010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL   = OPCODE_LENGTH'(5'b00011);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLTU  = OPCODE_LENGTH'(5'b00100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT   = OPCODE_LENGTH'(5'b00101);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = OPCODE_LENGTH'(5'b00110);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL   = OPCODE_LENGTH'(5'b00111);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA   = OPCODE_LENGTH'(5'b01000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR    = OPCODE_LENGTH'(5'b01001);
    localparam logic [OPCODE_LENGTH-1:0] OP_AND   = OPCODE_LENGTH'(5'b01010);
    localparam logic [OPCODE_LENGTH-1:0] OP_PASSB = OPCODE_LENGTH'(5'b01011);
    localparam logic [OPCODE_LENGTH-1:0] OP_BEQ   = OPCODE_LENGTH'(5'b01100);
    localparam logic [OPCODE_LENGTH-1:0] OP_BLT   = OPCODE_LENGTH'(5'b01101);
    localparam logic [OPCODE_LENGTH-1:0] OP_BGT   = OPCODE_LENGTH'(5'b01110);
    localparam logic [OPCODE_LENGTH-1:0] OP_BLTU  = OPCODE_LENGTH'(5'b01111);
    localparam logic [OPCODE_LENGTH-1:0] OP_BGTU  = OPCODE_LENGTH'(5'b10000);
    localparam logic [OPCODE_LENGTH-1:0] OP_MUL   = OPCODE_LENGTH'(5'b10001);

    localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONE_W  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [SH_W-1:0]       sh_s;
    logic [DATA_WIDTH-1:0] diff_s;
    logic                  lt_s_s;
    logic                  gt_s_s;
    logic                  lt_u_s;
    logic                  gt_u_s;
    logic [DATA_WIDTH-1:0] rd_next_s;
    logic                  blt_next_s;
    logic                  bgt_next_s;

    logic [DATA_WIDTH-1:0] rd_r;
    logic                  blt_r;
    logic                  bgt_r;
    logic                  zero_r;

    // Shared operand relations and shift amount used across several opcodes.
    always_comb begin
        sh_s   = bus.rs2[SH_W-1:0];
        diff_s = bus.rs1 - bus.rs2;
        lt_s_s = $signed(bus.rs1) < $signed(bus.rs2);
        gt_s_s = $signed(bus.rs1) > $signed(bus.rs2);
        lt_u_s = bus.rs1 < bus.rs2;
        gt_u_s = bus.rs1 > bus.rs2;
    end

    // Opcode decode into next result and branch conditions.
    always_comb begin
        rd_next_s  = ZERO_W;
        blt_next_s = 1'b0;
        bgt_next_s = 1'b0;
        case (bus.Opcode)
            OP_NOP:   rd_next_s = ZERO_W;
            OP_ADD:   rd_next_s = bus.rs1 + bus.rs2;
            OP_SUB:   rd_next_s = diff_s;
            OP_SLL:   rd_next_s = bus.rs1 << sh_s;
            OP_SLTU:  rd_next_s = lt_u_s ? ONE_W : ZERO_W;
            OP_SLT:   rd_next_s = lt_s_s ? ONE_W : ZERO_W;
            OP_XOR:   rd_next_s = bus.rs1 ^ bus.rs2;
            OP_SRL:   rd_next_s = bus.rs1 >> sh_s;
            OP_SRA:   rd_next_s = $unsigned($signed(bus.rs1) >>> sh_s);
            OP_OR:    rd_next_s = bus.rs1 | bus.rs2;
            OP_AND:   rd_next_s = bus.rs1 & bus.rs2;
            OP_PASSB: rd_next_s = bus.rs2;
            OP_BEQ:   rd_next_s = diff_s;
            OP_BLT: begin
                rd_next_s  = diff_s;
                blt_next_s = lt_s_s;
            end
            OP_BGT: begin
                rd_next_s  = diff_s;
                bgt_next_s = gt_s_s;
            end
            OP_BLTU: begin
                rd_next_s  = diff_s;
                blt_next_s = lt_u_s;
            end
            OP_BGTU: begin
                rd_next_s  = diff_s;
                bgt_next_s = gt_u_s;
            end
            OP_MUL:   rd_next_s = bus.rs1 * bus.rs2;
            default: begin
                rd_next_s  = ZERO_W;
                blt_next_s = 1'b0;
                bgt_next_s = 1'b0;
            end
        endcase
    end

    // Output registers; reset clears every output including zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_r   <= ZERO_W;
            blt_r  <= 1'b0;
            bgt_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            rd_r   <= rd_next_s;
            blt_r  <= blt_next_s;
            bgt_r  <= bgt_next_s;
            zero_r <= (rd_next_s == ZERO_W);
        end
    end

    assign bus.rd      = rd_r;
    assign bus.Con_BLT = blt_r;
    assign bus.Con_BGT = bgt_r;
    assign bus.zero    = zero_r;
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU with hand-computed expectations.
module tb_alu;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    alu_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) bus ();

    alu #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] e_rd,
                              input logic e_blt, input logic e_bgt, input logic e_z);
        check({tag, ".rd"},   bus.rd,               e_rd);
        check({tag, ".blt"},  {31'd0, bus.Con_BLT}, {31'd0, e_blt});
        check({tag, ".bgt"},  {31'd0, bus.Con_BGT}, {31'd0, e_bgt});
        check({tag, ".zero"}, {31'd0, bus.zero},    {31'd0, e_z});
    endtask

    task automatic run_vec(input string tag, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e_rd, input logic e_blt,
                           input logic e_bgt, input logic e_z);
        @(negedge clk);
        bus.Opcode = op;
        bus.rs1    = a;
        bus.rs2    = b;
        @(posedge clk);
        #1;
        check_outs(tag, e_rd, e_blt, e_bgt, e_z);
    endtask

    initial begin
        n_cmp      = 0;
        n_mis      = 0;
        rst_n      = 1'b0;
        bus.Opcode = 5'b00001;
        bus.rs1    = 32'd1;
        bus.rs2    = 32'd2;

        // Edges during reset must not load the pending ADD.
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 32'd0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outs("first_edge_add", 32'h0000_0003, 1'b0, 1'b0, 1'b0);

        run_vec("add_wrap",   5'b00001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_vec("sub",        5'b00010, 32'h0000_0003, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        run_vec("sub_neg",    5'b00010, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_vec("sll",        5'b00011, 32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
        run_vec("sll_hi_ign", 5'b00011, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        run_vec("sra",        5'b01000, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        run_vec("srl",        5'b00111, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
        run_vec("srl_31",     5'b00111, 32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_vec("sra_pos",    5'b01000, 32'h4000_0000, 32'h0000_001F, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_vec("sltu",       5'b00100, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_vec("sltu_big",   5'b00100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_vec("slt_neg",    5'b00101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_vec("xor",        5'b00110, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1'b0, 1'b0);
        run_vec("or",         5'b01001, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0);
        run_vec("and",        5'b01010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        run_vec("passb",      5'b01011, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        run_vec("beq",        5'b01100, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_vec("blt",        5'b01101, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0);
        run_vec("bgt_neg",    5'b01110, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        run_vec("bgt_pos",    5'b01110, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b1, 1'b0);
        run_vec("bltu_big",   5'b01111, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        run_vec("bltu_small", 5'b01111, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b0, 1'b0);
        run_vec("bgtu",       5'b10000, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0);
        run_vec("mul",        5'b10001, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 1'b0, 1'b0, 1'b0);
        run_vec("mul_wrap",   5'b10001, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_vec("mul_neg",    5'b10001, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        run_vec("nop",        5'b00000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_vec("undef_1f",   5'b11111, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_vec("undef_12",   5'b10010, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_vec("add",        5'b00001, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 1'b0);

        // Inputs changing between edges must leave the registered outputs alone.
        @(negedge clk);
        bus.Opcode = 5'b01101;
        bus.rs1    = 32'hFFFF_FFFE;
        bus.rs2    = 32'h0000_0001;
        #1;
        check_outs("hold", 32'h0000_0003, 1'b0, 1'b0, 1'b0);

        // Capture a BLT with a flag set, then reset away from any edge.
        @(posedge clk);
        #1;
        check_outs("pre_reset_blt", 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 32'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_outs("reset_held", 32'd0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n      = 1'b1;
        bus.Opcode = 5'b01011;
        bus.rs1    = 32'h0000_0000;
        bus.rs2    = 32'hCAFE_0001;
        @(posedge clk);
        #1;
        check_outs("after_reset", 32'hCAFE_0001, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
